// File: rtl/adder_slice_sequencer.sv
// adder_slice_sequencer: WIDTH-bit add using one SLICE-bit adder slice, one slice per cycle.
// Define ADDSEQ_SUB_EN to enable subtraction via op_sub (A-B, cout=1 means no borrow).
module adder_slice_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NSL = WIDTH / SLICE;
    localparam int CW = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] KLAST = CW'(NSL - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("WIDTH must be a multiple of SLICE");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [WIDTH-1:0] opa, opb, b_eff;
    logic             carry, c_eff;
    logic [CW-1:0]    k;
    logic [SLICE:0]   slice_sum;
    int               idx;

    // Subtraction folds into the add: B is inverted at accept and the +1 enters as carry-in.
`ifdef ADDSEQ_SUB_EN
    assign b_eff = op_sub ? ~b : b;
    assign c_eff = op_sub | cin;
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign b_eff = b;
    assign c_eff = cin;
`endif

    assign idx = int'(k);
    assign slice_sum = {1'b0, opa[idx*SLICE +: SLICE]} + {1'b0, opb[idx*SLICE +: SLICE]}
                     + {{SLICE{1'b0}}, carry};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            carry     <= 1'b0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    opa      <= a;
                    opb      <= b_eff;
                    carry    <= c_eff;
                    k        <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    sum[idx*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
                    carry                   <= slice_sum[SLICE];
                    if (k == KLAST) begin
                        cout      <= slice_sum[SLICE];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_slice_sequencer.sv
// tb_adder_slice_sequencer: directed vector table, hand sequences and random ops vs a reference model.
module tb_adder_slice_sequencer;
    logic        clk = 0, rst = 1, in_valid = 0, cin = 0, op_sub = 0, out_ready = 0;
    logic        in_ready, out_valid, cout, busy;
    logic [31:0] a = 0, b = 0, sum;
    int checks = 0, errors = 0, accepts = 0, handshakes = 0, aborted = 0, cyc;
    logic seen;

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
        int          stall;
        logic [31:0] es;
        logic        ec;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    adder_slice_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always @(posedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) accepts++;
            if (out_valid && out_ready) handshakes++;
        end
    end

    function automatic logic [32:0] model(input logic [31:0] x, y, input logic c, s);
`ifdef ADDSEQ_SUB_EN
        if (s) return {1'b0, x} + {1'b0, ~y} + 33'd1;
`endif
        return {1'b0, x} + {1'b0, y} + {32'd0, c};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic wait_valid();
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input logic [31:0] ta, tb_b, input logic tc, ts, input int stall,
                          input logic [31:0] es, input logic ec, input string nm);
        int n;
        a = ta; b = tb_b; cin = tc; op_sub = ts; in_valid = 1; out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 0; a = $urandom; b = $urandom; cin = 1'($urandom); op_sub = 1'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            chk({nm, " run ready/busy"}, {62'd0, in_ready, busy}, 64'b01);
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'd3);
        chk({nm, " done ready/busy"}, {62'd0, in_ready, busy}, 64'b01);
        chk({nm, " sum"}, {32'd0, sum}, {32'd0, es});
        chk({nm, " cout"}, {63'd0, cout}, {63'd0, ec});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({nm, " hold"}, {30'd0, out_valid, in_ready, cout, sum}, {30'd0, 1'b1, 1'b0, ec, es});
        end
        out_ready = 1;
        @(negedge clk);
        chk({nm, " idle"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
        out_ready = 0;
    endtask

    initial begin
        vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 0, 32'h00010000, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0, 32'h00000000, 1'b1};
        vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 5, 32'hACF13568, 1'b0};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1, 32'h00000000, 1'b1};
`ifdef ADDSEQ_SUB_EN
        vecs[4] = '{32'd5, 32'd7, 1'b0, 1'b1, 0, 32'hFFFFFFFE, 1'b0};
        vecs[5] = '{32'd7, 32'd5, 1'b0, 1'b1, 2, 32'd2, 1'b1};
`else
        vecs[4] = '{32'd5, 32'd7, 1'b0, 1'b1, 0, 32'd12, 1'b0};
        vecs[5] = '{32'd7, 32'd5, 1'b0, 1'b1, 2, 32'd12, 1'b0};
`endif
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 3, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 0, 32'h00010000, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset state", {27'd0, in_ready, out_valid, busy, cout, sum}, {27'd0, 4'b1000, 32'd0});
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                                           vecs[i].stall, vecs[i].es, vecs[i].ec, $sformatf("vec%0d", i));

        // Result held under back-pressure while a new request waits.
        a = 1; b = 2; cin = 0; op_sub = 0; in_valid = 1; out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        wait_valid();
        chk("stall sum", {32'd0, sum}, 64'd3);
        a = 100; b = 200; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall hold", {30'd0, out_valid, in_ready, cout, sum}, {30'd0, 3'b100, 32'd3});
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("stall exit idle", {62'd0, out_valid, in_ready}, 64'b01);
        @(negedge clk);
        in_valid = 0;
        chk("stall next accepted", {62'd0, in_ready, busy}, 64'b01);
        wait_valid();
        chk("stall next sum", {32'd0, sum}, 64'd300);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;

        // Reset mid-operation after the first slice has been written.
        a = 32'h1234; b = 1; cin = 0; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        rst = 1;
        aborted++;
        #1;
        chk("mid reset outputs", {27'd0, in_ready, out_valid, busy, cout, sum}, {27'd0, 4'b1000, 32'd0});
        @(negedge clk);
        rst = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("aborted op no valid", {63'd0, seen}, 64'd0);
        run_op(32'd5, 32'd7, 1'b0, 1'b0, 0, 32'd12, 1'b0, "after reset");

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            logic        rc, rs;
            logic [32:0] e;
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            e = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, $urandom_range(0, 3), e[31:0], e[32], "random");
        end

        chk("handshakes per accept", 64'(handshakes), 64'(accepts - aborted));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
